pwm_to_frequency: RTL and testbench
===================================

// Module: pwm_to_frequency
// PURPOSE
//  Measures the frequency of an incoming square/PWM wave and reports it in Hz on a 12-bit bus.
//  Inverse of the frequency-to-PWM generator: same 12-bit frequency word, opposite direction.
//  Used for loop-back self-test of the tone generator and for reading external tone inputs.
//  Method: count rising edges of the synchronised input over a fixed gate window of GATE_CYCLES clocks.
// PARAMETERS
//  CLK_HZ       25_000_000  system clock frequency; documentation and package default only
//  GATE_CYCLES  CLK_HZ      gate window length in clocks; CLK_HZ gives a 1 s gate, so result unit is Hz
//  FREQ_W       12          width of the frequency result; saturation value is 2**FREQ_W-1
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  rst        in   1       asynchronous, active-low reset
//  en         in   1       measurement enable; gating runs back-to-back while high
//  sig_in     in   1       asynchronous square/PWM input
//  frequency  out  12      last completed measurement, edges per gate, saturated
//  freq_valid out  1       one-cycle strobe, high in the cycle frequency updates
//  overflow   out  1       set with a result where the edge count exceeded 4095; cleared by the next result that does not
//  no_signal  out  1       set with a result of 0 edges; cleared by the next nonzero result
// BEHAVIOUR
//  Reset (rst=0, async): frequency=0, freq_valid=0, overflow=0, no_signal=0; sync flops=0; counters=0; FSM=IDLE.
//  Input path: 2-FF synchroniser, then a third flop; edge = s2 & ~s3.
//   The edge pulse is high for 1 clk, 3 clks after sig_in rises.
//  FSM IDLE: timer=0, edge_cnt=0; no result is produced.
//   en=1 -> GATE on the next clock. The first gate starts in the cycle after entry.
//  FSM GATE: timer counts 0..GATE_CYCLES-1.
//   edge_cnt increments on each edge cycle and saturates at 4096 (13-bit).
//  Terminal cycle (timer==GATE_CYCLES-1): total = edge_cnt + edge.
//   That clock: frequency <= min(total,4095); overflow <= (total>4095); no_signal <= (total==0);
//   freq_valid <= 1 for exactly 1 clk; timer <= 0; edge_cnt <= 0.
//   If en is still 1, stay in GATE; the next window starts with no gap cycle.
//  en=0 during GATE: abort to IDLE on the next clock; the partial count is discarded; no freq_valid.
//   frequency and flags hold their last values.
//  en=0 in the terminal cycle: the result is still published, then the FSM goes to IDLE.
//  Outputs hold between strobes. freq_valid is never high two cycles in a row unless GATE_CYCLES==1.
//   GATE_CYCLES>=2 is required; this is checked by elaboration assertion.
//  Max measurable edge rate is clk/2; faster inputs alias (not detected, documented limit).
//  Width rules: timer width is $clog2(GATE_CYCLES); all comparisons are unsigned.
// STRUCTURE
//  Shared package pwm_pkg: FREQ_W=12, CLK_HZ default, FREQ_MAX=4095, FSM state enum {IDLE,GATE}.
//   The frequency-to-PWM generator uses the same package.
//  Sub-module edge_sync: 2-FF synchroniser plus rising-edge detector.
//   Ports: clk, rst, d_async, q_sync, rise. It is reused by other async inputs.
//  Top: FSM, gate timer, saturating edge counter, result registers.
// TESTING  (bench uses GATE_CYCLES=1000)
//  1. Reset: hold rst=0 with sig_in toggling -> all outputs 0.
//     Release, en=0 for 5000 clks -> freq_valid never asserts.
//  2. en=1, sig_in period 100 clk (50/50), any phase -> every strobe frequency=10, overflow=0, no_signal=0.
//     Strobes are spaced exactly 1000 clks apart.
//  3. sig_in period 2 clk with GATE_CYCLES=10000 -> frequency=4095, overflow=1.
//     Then period 100 -> next full window gives 100, overflow=0.
//  4. sig_in held at 0 -> frequency=0, no_signal=1.
//     Then period 250 -> after the first full window frequency=4, no_signal=0.
//  5. Drop en at timer=500 -> no strobe and outputs unchanged.
//     Re-raise en -> first strobe 1001 clks later with a correct count.
//  6. Edge in the terminal cycle: place a rising edge so its pulse hits timer==999 -> it is counted in that window only.
//     Async rst=0 mid-gate -> outputs clear immediately, with no strobe.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the tone generator and the tone measurement paths.
package pwm_pkg;

   localparam int FREQ_W   = 12;
   localparam int CLK_HZ   = 25_000_000;
   localparam int FREQ_MAX = 2**FREQ_W - 1;

   typedef enum logic {IDLE, GATE} state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for an asynchronous input plus a one-clock rising-edge pulse.
module edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic d_async,
   output logic q_sync,
   output logic rise
);

   logic s1_p0, s2_p1, s3_p2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_p0 <= 1'b0;
         s2_p1 <= 1'b0;
         s3_p2 <= 1'b0;
      end else begin
         s1_p0 <= d_async;
         s2_p1 <= s1_p0;
         s3_p2 <= s2_p1;
      end
   end

   assign q_sync = s2_p1;
   assign rise   = s2_p1 & ~s3_p2;

endmodule

// File: rtl/pwm_to_frequency.sv
// Frequency meter: counts rising edges of sig_in over back-to-back gate windows.
module pwm_to_frequency #(
   parameter int CLK_HZ      = pwm_pkg::CLK_HZ,
   parameter int GATE_CYCLES = CLK_HZ,
   parameter int FREQ_W      = pwm_pkg::FREQ_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              sig_in,
   output logic [FREQ_W-1:0] frequency,
   output logic              freq_valid,
   output logic              overflow,
   output logic              no_signal
);
   import pwm_pkg::*;

   localparam int               TW      = $clog2(GATE_CYCLES);
   localparam int               CNT_W   = FREQ_W + 1;
   localparam logic [TW-1:0]    T_LAST  = TW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(1) << FREQ_W;

   if (GATE_CYCLES < 2) begin : g_gate_chk
      $error("GATE_CYCLES must be at least 2");
   end

   // Any total with the top bit set is beyond the result range and clamps to all ones.
   function automatic logic [FREQ_W-1:0] sat_freq(input logic [CNT_W-1:0] t);
      return t[FREQ_W] ? {FREQ_W{1'b1}} : t[FREQ_W-1:0];
   endfunction

   state_t           state;
   logic [TW-1:0]    timer;
   logic [CNT_W-1:0] edge_cnt;
   logic [CNT_W-1:0] total;
   logic             rise;
   logic             unused_sig_lvl;

   edge_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .d_async (sig_in),
      .q_sync  (unused_sig_lvl),
      .rise    (rise)
   );

   // An edge landing in the terminal cycle still belongs to the closing window.
   assign total = edge_cnt + CNT_W'(rise);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         timer      <= '0;
         edge_cnt   <= '0;
         frequency  <= '0;
         freq_valid <= 1'b0;
         overflow   <= 1'b0;
         no_signal  <= 1'b0;
      end else begin
         freq_valid <= 1'b0;
         case (state)
            IDLE: begin
               timer    <= '0;
               edge_cnt <= '0;
               if (en) state <= GATE;
            end
            GATE: begin
               if (timer == T_LAST) begin
                  frequency  <= sat_freq(total);
                  overflow   <= total[FREQ_W];
                  no_signal  <= (total == '0);
                  freq_valid <= 1'b1;
                  timer      <= '0;
                  edge_cnt   <= '0;
                  if (!en) state <= IDLE;
               end else if (!en) begin
                  state    <= IDLE;
                  timer    <= '0;
                  edge_cnt <= '0;
               end else begin
                  timer <= timer + 1'b1;
                  if (rise && edge_cnt != CNT_SAT) edge_cnt <= edge_cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_to_frequency.sv
// Scoreboard bench: 1000-clock gate meter (dut_a) plus a 10000-clock gate meter (dut_b) for saturation.
module tb_pwm_to_frequency;

   typedef struct packed {
      logic [11:0] f;
      logic        o;
      logic        n;
   } res_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en_a = 1'b0, en_b = 1'b0;
   logic        sig;
   logic        gen = 1'b0, man = 1'b0, use_gen = 1'b1;
   int          per = 0;
   int          gcnt = 0;
   logic [11:0] freq_a, freq_b;
   logic        fv_a, fv_b, ovf_a, ovf_b, nos_a, nos_b;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   strobes_a = 0;
   int   strobes_b = 0;
   res_t sb[$];

   assign sig = use_gen ? gen : man;

   pwm_to_frequency #(.GATE_CYCLES(1000)) dut_a (
      .clk(clk), .rst(rst), .en(en_a), .sig_in(sig),
      .frequency(freq_a), .freq_valid(fv_a), .overflow(ovf_a), .no_signal(nos_a)
   );

   pwm_to_frequency #(.GATE_CYCLES(10000)) dut_b (
      .clk(clk), .rst(rst), .en(en_b), .sig_in(sig),
      .frequency(freq_b), .freq_valid(fv_b), .overflow(ovf_b), .no_signal(nos_b)
   );

   always #5 clk = ~clk;

   // Square wave of per clocks, 50/50 duty; per<2 holds it low.
   initial begin
      forever begin
         @(negedge clk);
         if (per < 2) begin
            gcnt = 0;
            gen  = 1'b0;
         end else begin
            gcnt = (gcnt + 1 >= per) ? 0 : gcnt + 1;
            gen  = (gcnt < per / 2);
         end
      end
   end

   always @(negedge clk) begin
      if (fv_a === 1'b1) strobes_a++;
      if (fv_b === 1'b1) strobes_b++;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_strobe(input bit b, input int budget, output int cycles, output bit ok);
      ok = 1'b0;
      cycles = 0;
      while (!ok && cycles < budget) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
         if ((b ? fv_b : fv_a) === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      int s0;
      use_gen = 1'b1;
      per = 4;
      #1 rst = 1'b0;
      repeat (20) @(negedge clk);
      n_cmp++;
      if ({freq_a, fv_a, ovf_a, nos_a, freq_b, fv_b, ovf_b, nos_b} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got a=%h/%b/%b/%b b=%h/%b/%b/%b required all 0",
                  freq_a, fv_a, ovf_a, nos_a, freq_b, fv_b, ovf_b, nos_b);
      end
      rst = 1'b1;
      s0 = strobes_a + strobes_b;
      repeat (5000) @(negedge clk);
      n_cmp++;
      if (strobes_a + strobes_b != s0) begin
         n_bad++;
         $display("FAIL idle_no_strobe: got %0d strobes required 0", strobes_a + strobes_b - s0);
      end
      n_cmp++;
      if ({freq_a, ovf_a, nos_a} !== '0) begin
         n_bad++;
         $display("FAIL idle_outputs: got %h/%b/%b required 0/0/0", freq_a, ovf_a, nos_a);
      end
   endtask

   task automatic test_rate();
      int cyc;
      bit ok;
      res_t e;
      per = 100;
      repeat (300) @(negedge clk);
      en_a = 1'b1;
      for (int k = 0; k < 3; k++) begin
         sb.push_back('{f: 12'd10, o: 1'b0, n: 1'b0});
         wait_strobe(1'b0, 1100, cyc, ok);
         e = sb.pop_front();
         n_cmp++;
         if (!ok || cyc != ((k == 0) ? 1001 : 1000)) begin
            n_bad++;
            $display("FAIL rate_spacing[%0d]: got %0d clks (seen=%0b) required %0d", k, cyc, ok,
                     (k == 0) ? 1001 : 1000);
         end
         n_cmp++;
         if ({freq_a, ovf_a, nos_a} !== e) begin
            n_bad++;
            $display("FAIL rate_result[%0d]: got %0d/%b/%b required %0d/%b/%b",
                     k, freq_a, ovf_a, nos_a, e.f, e.o, e.n);
         end
      end
   endtask

   task automatic test_overflow();
      int cyc;
      bit ok;
      res_t e;
      @(negedge clk);
      en_a = 1'b0;
      per = 2;
      repeat (20) @(negedge clk);
      en_b = 1'b1;
      sb.push_back('{f: 12'd4095, o: 1'b1, n: 1'b0});
      wait_strobe(1'b1, 10100, cyc, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || {freq_b, ovf_b, nos_b} !== e) begin
         n_bad++;
         $display("FAIL overflow_sat: got %0d/%b/%b (seen=%0b) required %0d/%b/%b",
                  freq_b, ovf_b, nos_b, ok, e.f, e.o, e.n);
      end
      per = 100;
      wait_strobe(1'b1, 10100, cyc, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL overflow_skip: got no strobe in %0d clks required one", cyc);
      end
      sb.push_back('{f: 12'd100, o: 1'b0, n: 1'b0});
      wait_strobe(1'b1, 10100, cyc, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || cyc != 10000 || {freq_b, ovf_b, nos_b} !== e) begin
         n_bad++;
         $display("FAIL overflow_clear: got %0d/%b/%b after %0d clks required %0d/%b/%b after 10000",
                  freq_b, ovf_b, nos_b, cyc, e.f, e.o, e.n);
      end
      en_b = 1'b0;
   endtask

   task automatic test_no_signal();
      int cyc;
      bit ok;
      res_t e;
      per = 0;
      repeat (10) @(negedge clk);
      en_a = 1'b1;
      sb.push_back('{f: 12'd0, o: 1'b0, n: 1'b1});
      wait_strobe(1'b0, 1100, cyc, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || {freq_a, ovf_a, nos_a} !== e) begin
         n_bad++;
         $display("FAIL no_signal_set: got %0d/%b/%b (seen=%0b) required %0d/%b/%b",
                  freq_a, ovf_a, nos_a, ok, e.f, e.o, e.n);
      end
      per = 250;
      wait_strobe(1'b0, 1100, cyc, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL no_signal_skip: got no strobe in %0d clks required one", cyc);
      end
      sb.push_back('{f: 12'd4, o: 1'b0, n: 1'b0});
      wait_strobe(1'b0, 1100, cyc, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || {freq_a, ovf_a, nos_a} !== e) begin
         n_bad++;
         $display("FAIL no_signal_clear: got %0d/%b/%b (seen=%0b) required %0d/%b/%b",
                  freq_a, ovf_a, nos_a, ok, e.f, e.o, e.n);
      end
   endtask

   task automatic test_abort();
      int cyc;
      int s0;
      bit ok;
      res_t e;
      repeat (500) @(posedge clk);
      @(negedge clk);
      en_a = 1'b0;
      s0 = strobes_a;
      repeat (1500) @(negedge clk);
      n_cmp++;
      if (strobes_a != s0 || {freq_a, ovf_a, nos_a} !== {12'd4, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL abort_hold: got %0d strobes, %0d/%b/%b required 0 strobes, 4/0/0",
                  strobes_a - s0, freq_a, ovf_a, nos_a);
      end
      en_a = 1'b1;
      sb.push_back('{f: 12'd4, o: 1'b0, n: 1'b0});
      wait_strobe(1'b0, 1100, cyc, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || cyc != 1001 || {freq_a, ovf_a, nos_a} !== e) begin
         n_bad++;
         $display("FAIL abort_restart: got %0d/%b/%b after %0d clks required %0d/%b/%b after 1001",
                  freq_a, ovf_a, nos_a, cyc, e.f, e.o, e.n);
      end
   endtask

   task automatic test_terminal_edge_and_reset();
      int cyc;
      int s0;
      bit ok;
      res_t e;
      man = 1'b0;
      use_gen = 1'b0;
      wait_strobe(1'b0, 1100, cyc, ok);
      sb.push_back('{f: 12'd0, o: 1'b0, n: 1'b1});
      wait_strobe(1'b0, 1100, cyc, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || {freq_a, ovf_a, nos_a} !== e) begin
         n_bad++;
         $display("FAIL quiet_window: got %0d/%b/%b (seen=%0b) required %0d/%b/%b",
                  freq_a, ovf_a, nos_a, ok, e.f, e.o, e.n);
      end
      // Rise before the 998th edge after the strobe puts the pulse on timer==999.
      sb.push_back('{f: 12'd1, o: 1'b0, n: 1'b0});
      repeat (997) @(posedge clk);
      @(negedge clk);
      man = 1'b1;
      wait_strobe(1'b0, 10, cyc, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || cyc != 3 || {freq_a, ovf_a, nos_a} !== e) begin
         n_bad++;
         $display("FAIL terminal_edge: got %0d/%b/%b after %0d clks required %0d/%b/%b after 3",
                  freq_a, ovf_a, nos_a, cyc, e.f, e.o, e.n);
      end
      repeat (4) @(negedge clk);
      man = 1'b0;
      sb.push_back('{f: 12'd0, o: 1'b0, n: 1'b1});
      wait_strobe(1'b0, 1100, cyc, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || {freq_a, ovf_a, nos_a} !== e) begin
         n_bad++;
         $display("FAIL terminal_next: got %0d/%b/%b (seen=%0b) required %0d/%b/%b",
                  freq_a, ovf_a, nos_a, ok, e.f, e.o, e.n);
      end
      per = 100;
      use_gen = 1'b1;
      wait_strobe(1'b0, 1100, cyc, ok);
      sb.push_back('{f: 12'd10, o: 1'b0, n: 1'b0});
      wait_strobe(1'b0, 1100, cyc, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || {freq_a, ovf_a, nos_a} !== e) begin
         n_bad++;
         $display("FAIL pre_reset: got %0d/%b/%b (seen=%0b) required %0d/%b/%b",
                  freq_a, ovf_a, nos_a, ok, e.f, e.o, e.n);
      end
      repeat (300) @(negedge clk);
      s0 = strobes_a;
      #1 rst = 1'b0;
      #1;
      n_cmp++;
      if ({freq_a, fv_a, ovf_a, nos_a} !== '0) begin
         n_bad++;
         $display("FAIL async_reset: got %0d/%b/%b/%b required 0/0/0/0", freq_a, fv_a, ovf_a, nos_a);
      end
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      n_cmp++;
      if (strobes_a != s0 || freq_a !== 12'd0) begin
         n_bad++;
         $display("FAIL reset_no_strobe: got %0d strobes freq %0d required 0 strobes freq 0",
                  strobes_a - s0, freq_a);
      end
      en_a = 1'b0;
   endtask

   initial begin
      test_reset();
      test_rate();
      test_overflow();
      test_no_signal();
      test_abort();
      test_terminal_edge_and_reset();
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
